// File: rtl/sdp_bwe_bram_ctl_if.sv
// Bus bundle for sdp_bwe_bram_ctl: clear-sweep control, byte-enable write port
// and pipelined read port. AW must equal clog2(RAM_DEPTH) (minimum 1) of the attached RAM.
interface sdp_bwe_bram_ctl_if #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int AW        = 9
);
    logic                        init_req;
    logic                        init_busy;
    logic                        wr_en;
    logic [AW-1:0]               wr_addr;
    logic [NB_COL*COL_WIDTH-1:0] wr_data;
    logic [NB_COL-1:0]           wr_be;
    logic                        rd_en;
    logic [AW-1:0]               rd_addr;
    logic [NB_COL*COL_WIDTH-1:0] rd_data;
    logic                        rd_valid;

    modport master (
        output init_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  init_busy, rd_data, rd_valid
    );

    modport slave (
        input  init_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output init_busy, rd_data, rd_valid
    );
endinterface

// File: rtl/sdp_bwe_bram_ctl.sv
// Single-clock simple-dual-port byte-write RAM with clear sweep and RD_LAT-deep read pipeline.
// Define BRAM_BYPASS_EN to forward same-cycle same-address writes into the read (byte-merged).
module sdp_bwe_bram_ctl #(
    parameter int                                NB_COL    = 4,
    parameter int                                COL_WIDTH = 8,
    parameter int                                RAM_DEPTH = 512,
    parameter int                                RD_LAT    = 2,
    parameter logic [NB_COL*COL_WIDTH-1:0]       INIT_WORD = '0
) (
    input  logic              clk,
    input  logic              rstn,
    sdp_bwe_bram_ctl_if.slave bus
);
    localparam int              DW        = NB_COL * COL_WIDTH;
    localparam int              AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_EXT = (AW+1)'(RAM_DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(RAM_DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                   state_q;
    logic [AW-1:0]            sweep_addr_q;
    logic                     init_busy_q;
    logic [DW-1:0]            mem [RAM_DEPTH];

    logic                     wr_ok;
    logic                     rd_ok;
    logic                     rd_in_range;
    logic [DW-1:0]            rd_word;

    logic [RD_LAT-1:0]          vld_q;
    logic [RD_LAT-1:0][DW-1:0]  dat_q;

    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;
    assign wr_ok       = bus.wr_en && (state_q == READY) && ({1'b0, bus.wr_addr} < DEPTH_EXT);
    assign rd_ok       = bus.rd_en && (state_q == READY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= CLEAR;
            sweep_addr_q <= '0;
            init_busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    // init_req is deliberately not looked at here: a running sweep is never restarted.
                    if (sweep_addr_q == LAST_ADDR) begin
                        state_q     <= READY;
                        init_busy_q <= 1'b0;
                    end else begin
                        sweep_addr_q <= sweep_addr_q + AW'(1);
                    end
                end
                READY: begin
                    if (bus.init_req) begin
                        state_q      <= CLEAR;
                        sweep_addr_q <= '0;
                        init_busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: the array has no reset; the sweep initialises it, and a resettable array cannot map to block RAM.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[sweep_addr_q] <= INIT_WORD;
        end else if (wr_ok) begin
            for (int i = 0; i < NB_COL; i++) begin
                // NOTE: non-blocking write, so a read of this address on the same edge still sees the old word.
                if (bus.wr_be[i]) mem[bus.wr_addr][i*COL_WIDTH +: COL_WIDTH] <= bus.wr_data[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    always_comb begin
        // NOTE: default first, so every path assigns rd_word and no latch is inferred.
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.rd_addr];
`ifdef BRAM_BYPASS_EN
            if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
                for (int i = 0; i < NB_COL; i++) begin
                    if (bus.wr_be[i]) rd_word[i*COL_WIDTH +: COL_WIDTH] = bus.wr_data[i*COL_WIDTH +: COL_WIDTH];
                end
            end
`endif
        end
    end

    // Each stage only loads when its input is valid, so the last stage holds the previous result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= rd_ok;
            if (rd_ok) dat_q[0] <= rd_word;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign bus.rd_data   = dat_q[RD_LAT-1];
    assign bus.rd_valid  = vld_q[RD_LAT-1];
    assign bus.init_busy = init_busy_q;
endmodule

// File: tb/tb_sdp_bwe_bram_ctl.sv
// Self-checking bench for sdp_bwe_bram_ctl: two instances (512 words/RD_LAT 2 and
// 300 words/RD_LAT 3) driven with directed and random traffic, checked against a word-array model.
module tb_sdp_bwe_bram_ctl;
    localparam int          NB_COL    = 4;
    localparam int          COL_WIDTH = 8;
    localparam int          AW        = 9;
    localparam int          DEPTH_A   = 512;
    localparam int          LAT_A     = 2;
    localparam logic [31:0] INIT_A    = 32'hA5A5_A5A5;
    localparam int          DEPTH_B   = 300;
    localparam int          LAT_B     = 3;
    localparam logic [31:0] INIT_B    = 32'h5A5A_0F0F;
    localparam int          NLOG      = 8192;
`ifdef BRAM_BYPASS_EN
    localparam bit          BYPASS    = 1'b1;
`else
    localparam bit          BYPASS    = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;
    always #5 clk = ~clk;

    sdp_bwe_bram_ctl_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .AW(AW)) bus_a ();
    sdp_bwe_bram_ctl_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .AW(AW)) bus_b ();

    sdp_bwe_bram_ctl #(
        .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(DEPTH_A), .RD_LAT(LAT_A), .INIT_WORD(INIT_A)
    ) dut_a (
        .clk(clk), .rstn(rstn_a), .bus(bus_a.slave)
    );

    sdp_bwe_bram_ctl #(
        .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(DEPTH_B), .RD_LAT(LAT_B), .INIT_WORD(INIT_B)
    ) dut_b (
        .clk(clk), .rstn(rstn_b), .bus(bus_b.slave)
    );

    int errors = 0;
    int checks = 0;
    int n      = 0;

    int        depth_of [2] = '{DEPTH_A, DEPTH_B};
    int        lat_of   [2] = '{LAT_A, LAT_B};
    bit [31:0] init_of  [2] = '{INIT_A, INIT_B};

    // Model: word contents, remaining sweep cycles, last delivered read result.
    bit [31:0] m_mem  [2][512];
    int        m_busy [2];
    bit [31:0] m_hold [2];

    // Per-cycle expected and observed outputs, indexed by the cycle count n.
    bit        exp_v [2][NLOG];
    bit [31:0] exp_d [2][NLOG];
    bit [31:0] exp_h [2][NLOG];
    bit        exp_b [2][NLOG];
    logic        obs_v [2][NLOG];
    logic [31:0] obs_d [2][NLOG];
    logic        obs_b [2][NLOG];

    // One clock on both instances: instance d gets the given inputs, the other idles.
    task automatic cyc(input int d, input bit init_req, input bit wr_en, input int wr_addr,
                       input bit [31:0] wr_data, input bit [3:0] wr_be, input bit rd_en, input int rd_addr);
        bit [31:0] val;
        bit        act;
        bit        in_rst;
        bus_a.init_req = (d == 0) && init_req;
        bus_a.wr_en    = (d == 0) && wr_en;
        bus_a.wr_addr  = AW'(wr_addr);
        bus_a.wr_data  = wr_data;
        bus_a.wr_be    = wr_be;
        bus_a.rd_en    = (d == 0) && rd_en;
        bus_a.rd_addr  = AW'(rd_addr);
        bus_b.init_req = (d == 1) && init_req;
        bus_b.wr_en    = (d == 1) && wr_en;
        bus_b.wr_addr  = AW'(wr_addr);
        bus_b.wr_data  = wr_data;
        bus_b.wr_be    = wr_be;
        bus_b.rd_en    = (d == 1) && rd_en;
        bus_b.rd_addr  = AW'(rd_addr);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            act    = (k == d);
            in_rst = (k == 0) ? !rstn_a : !rstn_b;
            if (in_rst) begin
                m_busy[k] = depth_of[k];
                m_hold[k] = '0;
                for (int a = 0; a < 512; a++) m_mem[k][a] = init_of[k];
            end else begin
                if (act && rd_en && m_busy[k] == 0) begin
                    val = (rd_addr < depth_of[k]) ? m_mem[k][rd_addr] : 32'h0;
                    if (BYPASS && wr_en && wr_addr == rd_addr && rd_addr < depth_of[k])
                        for (int i = 0; i < 4; i++) if (wr_be[i]) val[i*8 +: 8] = wr_data[i*8 +: 8];
                    exp_v[k][n + lat_of[k]] = 1'b1;
                    exp_d[k][n + lat_of[k]] = val;
                end
                if (act && wr_en && m_busy[k] == 0 && wr_addr < depth_of[k])
                    for (int i = 0; i < 4; i++) if (wr_be[i]) m_mem[k][wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
                if (m_busy[k] > 0) begin
                    m_busy[k]--;
                end else if (act && init_req) begin
                    m_busy[k] = depth_of[k];
                    for (int a = 0; a < 512; a++) m_mem[k][a] = init_of[k];
                end
            end
        end
        n++;
        for (int k = 0; k < 2; k++) begin
            if (exp_v[k][n]) m_hold[k] = exp_d[k][n];
            exp_h[k][n] = m_hold[k];
            exp_b[k][n] = (m_busy[k] > 0);
        end
        @(negedge clk);
        obs_v[0][n] = bus_a.rd_valid;
        obs_d[0][n] = bus_a.rd_data;
        obs_b[0][n] = bus_a.init_busy;
        obs_v[1][n] = bus_b.rd_valid;
        obs_d[1][n] = bus_b.rd_data;
        obs_b[1][n] = bus_b.init_busy;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) cyc(0, 1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0);
    endtask

    task automatic wr(input int d, input int addr, input bit [31:0] data, input bit [3:0] be);
        cyc(d, 1'b0, 1'b1, addr, data, be, 1'b0, 0);
    endtask

    task automatic rd(input int d, input int addr);
        cyc(d, 1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1, addr);
    endtask

    task automatic test_reset();
        int c0;
        int done_a;
        int done_b;
        c0 = n + 1;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        idle(3);
        checks++;
        if (bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 32'h0 || bus_a.init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: valid=%b data=%h busy=%b, want 0 00000000 1", bus_a.rd_valid, bus_a.rd_data, bus_a.init_busy);
        end
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        done_a = 0;
        done_b = 0;
        for (int g = 1; g <= 600 && done_a == 0; g++) begin
            idle(1);
            if (done_b == 0 && obs_b[1][n] === 1'b0) done_b = g;
            if (obs_b[0][n] === 1'b0) done_a = g;
        end
        checks++;
        if (done_a != DEPTH_A) begin
            errors++;
            $display("FAIL sweep_len_a: busy for %0d cycles, want %0d", done_a, DEPTH_A);
        end
        checks++;
        if (done_b != DEPTH_B) begin
            errors++;
            $display("FAIL sweep_len_b: busy for %0d cycles, want %0d", done_b, DEPTH_B);
        end
        for (int c = c0; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL reset dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_clear_contents();
        int t;
        t = n;
        rd(0, 0);
        rd(0, 511);
        idle(4);
        checks++;
        if (obs_v[0][t+1] !== 1'b0 || obs_v[0][t+2] !== 1'b1 || obs_d[0][t+2] !== INIT_A) begin
            errors++;
            $display("FAIL clear_addr0: v(t+1)=%b v(t+2)=%b d=%h, want 0 1 %h", obs_v[0][t+1], obs_v[0][t+2], obs_d[0][t+2], INIT_A);
        end
        checks++;
        if (obs_v[0][t+3] !== 1'b1 || obs_d[0][t+3] !== INIT_A) begin
            errors++;
            $display("FAIL clear_addr511: v=%b d=%h, want 1 %h", obs_v[0][t+3], obs_d[0][t+3], INIT_A);
        end
        for (int c = t + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL clear_contents dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_byte_write();
        int t0;
        int t;
        t0 = n;
        wr(0, 5, 32'h1122_3344, 4'b1111);
        wr(0, 5, 32'hFFEE_DDCC, 4'b0101);
        wr(0, 6, 32'h7777_7777, 4'b0000);
        t = n;
        rd(0, 5);
        rd(0, 6);
        idle(4);
        checks++;
        if (obs_v[0][t+1] !== 1'b0 || obs_v[0][t+2] !== 1'b1 || obs_d[0][t+2] !== 32'h11EE_33CC) begin
            errors++;
            $display("FAIL byte_merge: v(t+1)=%b v(t+2)=%b d=%h, want 0 1 11ee33cc", obs_v[0][t+1], obs_v[0][t+2], obs_d[0][t+2]);
        end
        checks++;
        if (obs_d[0][t+3] !== INIT_A) begin
            errors++;
            $display("FAIL be_zero_noop: d=%h, want %h", obs_d[0][t+3], INIT_A);
        end
        for (int c = t0 + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL byte_write dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_collision();
        int t0;
        int t1;
        int t2;
        bit [31:0] want_full;
        bit [31:0] want_half;
        want_full = BYPASS ? 32'hDEAD_BEEF : 32'h0;
        want_half = BYPASS ? 32'h0000_BEEF : 32'h0;
        t0 = n;
        wr(0, 9, 32'h0, 4'b1111);
        wr(0, 10, 32'h0, 4'b1111);
        t1 = n;
        cyc(0, 1'b0, 1'b1, 9, 32'hDEAD_BEEF, 4'b1111, 1'b1, 9);
        t2 = n;
        cyc(0, 1'b0, 1'b1, 10, 32'hDEAD_BEEF, 4'b0011, 1'b1, 10);
        rd(0, 9);
        rd(0, 10);
        idle(4);
        checks++;
        if (obs_v[0][t1+2] !== 1'b1 || obs_d[0][t1+2] !== want_full) begin
            errors++;
            $display("FAIL collision_full: v=%b d=%h, want 1 %h", obs_v[0][t1+2], obs_d[0][t1+2], want_full);
        end
        checks++;
        if (obs_v[0][t2+2] !== 1'b1 || obs_d[0][t2+2] !== want_half) begin
            errors++;
            $display("FAIL collision_half: v=%b d=%h, want 1 %h", obs_v[0][t2+2], obs_d[0][t2+2], want_half);
        end
        checks++;
        if (obs_d[0][t2+3] !== 32'hDEAD_BEEF || obs_d[0][t2+4] !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL after_collision: d9=%h d10=%h, want deadbeef 0000beef", obs_d[0][t2+3], obs_d[0][t2+4]);
        end
        for (int c = t0 + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL collision dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_back_to_back();
        int t;
        int run;
        t = n;
        for (int i = 0; i < 8; i++) rd(0, i);
        idle(4);
        run = 0;
        for (int i = 0; i < 8; i++) if (obs_v[0][t+LAT_A+i] === 1'b1) run++;
        checks++;
        if (run != 8 || obs_v[0][t+LAT_A+8] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_run: %0d consecutive valids, trailing v=%b, want 8 and 0", run, obs_v[0][t+LAT_A+8]);
        end
        for (int c = t + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_out_of_range();
        int t;
        t = n;
        wr(1, 300, 32'h1234_5678, 4'b1111);
        rd(1, 300);
        for (int a = 0; a < DEPTH_B; a++) rd(1, a);
        idle(5);
        checks++;
        if (obs_v[1][t+1+LAT_B] !== 1'b1 || obs_d[1][t+1+LAT_B] !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: v=%b d=%h, want 1 00000000", obs_v[1][t+1+LAT_B], obs_d[1][t+1+LAT_B]);
        end
        for (int c = t + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL out_of_range dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_random();
        int t;
        int d;
        int wa;
        int ra;
        t = n;
        for (int i = 0; i < 400; i++) begin
            d  = int'($urandom_range(0, 1));
            wa = (d == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(280, 320));
            ra = ($urandom_range(0, 3) == 0) ? wa : ((d == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(280, 320)));
            cyc(d, 1'b0, 1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), ra);
        end
        idle(5);
        for (int c = t + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_init_sweep();
        int t0;
        int t;
        int done;
        t0 = n;
        wr(0, 3, 32'hCAFE_F00D, 4'b1111);
        t = n;
        cyc(0, 1'b1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 3);
        checks++;
        if (obs_b[0][t+1] !== 1'b1) begin
            errors++;
            $display("FAIL init_busy_next: busy=%b, want 1", obs_b[0][t+1]);
        end
        done = 0;
        for (int g = 1; g <= 600 && done == 0; g++) begin
            if (g <= 100) cyc(0, g == 50, 1'b1, 3, 32'h0BAD_BEEF, 4'b1111, 1'b1, 3);
            else idle(1);
            if (obs_b[0][n] === 1'b0) done = g;
        end
        checks++;
        if (done != DEPTH_A) begin
            errors++;
            $display("FAIL init_sweep_len: busy for %0d cycles after init, want %0d", done, DEPTH_A);
        end
        checks++;
        if (obs_v[0][t+LAT_A] !== 1'b1 || obs_d[0][t+LAT_A] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL read_before_init: v=%b d=%h, want 1 cafef00d", obs_v[0][t+LAT_A], obs_d[0][t+LAT_A]);
        end
        t = n;
        rd(0, 3);
        idle(3);
        checks++;
        if (obs_v[0][t+LAT_A] !== 1'b1 || obs_d[0][t+LAT_A] !== INIT_A) begin
            errors++;
            $display("FAIL cleared_addr3: v=%b d=%h, want 1 %h", obs_v[0][t+LAT_A], obs_d[0][t+LAT_A], INIT_A);
        end
        for (int c = t0 + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL init_sweep dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    task automatic test_reset_mid_sweep();
        int t0;
        int done;
        t0 = n;
        wr(0, 7, 32'h1357_9BDF, 4'b1111);
        rd(0, 7);
        idle(3);
        cyc(0, 1'b1, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0);
        idle(200);
        rstn_a = 1'b0;
        #1;
        checks++;
        if (bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 32'h0 || bus_a.init_busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: v=%b d=%h busy=%b, want 0 00000000 1", bus_a.rd_valid, bus_a.rd_data, bus_a.init_busy);
        end
        for (int i = n + 1; i <= n + 8; i++) exp_v[0][i] = 1'b0;
        idle(3);
        rstn_a = 1'b1;
        done = 0;
        for (int g = 1; g <= 600 && done == 0; g++) begin
            idle(1);
            if (obs_b[0][n] === 1'b0) done = g;
        end
        checks++;
        if (done != DEPTH_A) begin
            errors++;
            $display("FAIL resweep_len: busy for %0d cycles after release, want %0d", done, DEPTH_A);
        end
        rd(0, 7);
        rd(0, 300);
        idle(3);
        for (int c = t0 + 1; c <= n; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k][c] !== exp_v[k][c] || obs_d[k][c] !== exp_h[k][c] || obs_b[k][c] !== exp_b[k][c]) begin
                    errors++;
                    $display("FAIL reset_mid_sweep dut%0d cycle %0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                             k, c, obs_v[k][c], obs_d[k][c], obs_b[k][c], exp_v[k][c], exp_h[k][c], exp_b[k][c]);
                end
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clear_contents();
        test_byte_write();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_init_sweep();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
